// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the bit-serial ALU operation scheduler.
package alu_sched_pkg;

  localparam int OP_BITS = 3;

  // Operation codes used by the decoder for single-byte ops
  localparam logic [OP_BITS-1:0] OP_ADD = 3'd0;

  // Packed parameter bundle driven onto the ALU for the whole operation
  typedef struct packed {
    logic [OP_BITS-1:0] operation;
    logic               external_arg1;
    logic               external_arg2;
    logic               pair_op;
    logic               pair_op2;
    logic               sext2;
    logic [2:0]         arg2_limit_length;
    logic               reg1;
    logic               reg2;
    logic               update_reg1;
    logic               reverse_args;
    logic               double_arg2;
    logic               output_scan_out;
    logic               update_carry_flags;
    logic               update_other_flags;
    logic               rotate;
    logic               do_shr;
    logic [2:0]         rotate_count;
  } alu_op_desc_t;

  localparam int ALU_DESC_W = $bits(alu_op_desc_t);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } sched_state_t;

  localparam logic ID_DECODER = 1'b0;
  localparam logic ID_DEBUG   = 1'b1;

endpackage

// File: rtl/alu_op_fifo.sv
// Port-0 (decoder) operation queue with synchronous flush.
// Head entry is readable combinationally so the scheduler can latch it
// into the ALU parameter register at the same edge it pops.
module alu_op_fifo
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = ALU_DESC_W,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_reg == FULL_CNT);
  assign empty   = (count_reg == '0);
  // A write racing a flush is dropped; a pop racing a flush still delivers data
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr_reg];

  // Storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares the bit-serial ALU between the decoder (port 0, queued) and the
// debug port (port 1, unbuffered). Holds op_valid and the parameter bundle
// stable until op_done and can issue back-to-back on the done edge.
// Optional feature macro: ALU_SCHED_DEBUG_EN enables port 1 and round-robin
// arbitration; without it port 1 is inert and done_id is always 0.
// The ALU's own reset must be tied to the same reset net as this block,
// since alu_op_valid drops asynchronously when reset asserts.
module alu_op_scheduler
  import alu_sched_pkg::*;
#(
  parameter int DESC_BITS  = ALU_DESC_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req0_valid,
  input  logic [DESC_BITS-1:0] req0_desc,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [DESC_BITS-1:0] req1_desc,
  output logic                 req1_ready,
  input  logic                 flush,
  output logic                 alu_op_valid,
  output logic [DESC_BITS-1:0] alu_desc,
  input  logic                 alu_op_done,
  output logic                 done_valid,
  output logic                 done_id,
  output logic                 busy
);

  sched_state_t         state_reg;
  logic [DESC_BITS-1:0] alu_desc_reg;
  logic [DESC_BITS-1:0] fifo_head;
  logic [DESC_BITS-1:0] issue_desc;
  logic                 done_valid_reg;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 fifo_pop;
  logic                 cand0;
  logic                 cand1;
  logic                 win_id;
  logic                 slot_free;
  logic                 issue;
  logic                 completing;

  alu_op_fifo #(
    .WIDTH (DESC_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (req0_valid && req0_ready),
    .pop     (fifo_pop),
    .flush   (flush),
    .wr_data (req0_desc),
    .rd_data (fifo_head),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign req0_ready   = !fifo_full;
  assign cand0        = !fifo_empty;
  // The ALU is free when idle or when the current op finishes this cycle
  assign slot_free    = (state_reg == S_IDLE) || alu_op_done;
  assign issue        = slot_free && (cand0 || cand1);
  assign completing   = (state_reg == S_RUN) && alu_op_done;
  assign fifo_pop     = issue && (win_id == ID_DECODER);
  assign alu_op_valid = (state_reg == S_RUN);
  assign alu_desc     = alu_desc_reg;
  assign done_valid   = done_valid_reg;
  assign busy         = (state_reg == S_RUN) || !fifo_empty;

`ifdef ALU_SCHED_DEBUG_EN
  logic last_id_reg;
  logic cur_id_reg;
  logic done_id_reg;

  assign cand1      = req1_valid;
  // On contention the port that did not issue last time wins
  assign win_id     = (cand0 && cand1) ? ~last_id_reg : cand1;
  assign req1_ready = issue && (win_id == ID_DEBUG);
  assign issue_desc = (win_id == ID_DEBUG) ? req1_desc : fifo_head;
  assign done_id    = done_id_reg;

  // Round-robin history, in-flight owner and completion owner
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_id_reg <= ID_DECODER;
      cur_id_reg  <= ID_DECODER;
      done_id_reg <= ID_DECODER;
    end else begin
      if (issue) begin
        last_id_reg <= win_id;
        cur_id_reg  <= win_id;
      end
      if (completing) begin
        done_id_reg <= cur_id_reg;
      end
    end
  end
`else
  logic unused_req1;

  assign cand1       = 1'b0;
  assign win_id      = ID_DECODER;
  assign req1_ready  = 1'b0;
  assign issue_desc  = fifo_head;
  assign done_id     = ID_DECODER;
  assign unused_req1 = ^{req1_valid, req1_desc};
`endif

  // Issue/run sequencing; parameters only change at an issue edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= S_IDLE;
      alu_desc_reg   <= '0;
      done_valid_reg <= 1'b0;
    end else begin
      done_valid_reg <= completing;
      if (issue) begin
        state_reg    <= S_RUN;
        alu_desc_reg <= issue_desc;
      end else if (completing) begin
        state_reg    <= S_IDLE;
      end
    end
  end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Self-checking bench for alu_op_scheduler: directed scenarios with literal
// expectations plus randomized traffic compared every cycle against a
// queue-based reference model and a simple ALU run-length model.
module tb_alu_op_scheduler;
  import alu_sched_pkg::*;

  localparam int DW    = 24;
  localparam int DEPTH = 2;
`ifdef ALU_SCHED_DEBUG_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid;
  logic [DW-1:0] req0_desc;
  logic          req0_ready;
  logic          req1_valid;
  logic [DW-1:0] req1_desc;
  logic          req1_ready;
  logic          flush;
  logic          alu_op_valid;
  logic [DW-1:0] alu_desc;
  logic          alu_op_done;
  logic          done_valid;
  logic          done_id;
  logic          busy;

  always #5 clk = ~clk;

  alu_op_scheduler #(.DESC_BITS(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .req0_valid   (req0_valid),
    .req0_desc    (req0_desc),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_desc    (req1_desc),
    .req1_ready   (req1_ready),
    .flush        (flush),
    .alu_op_valid (alu_op_valid),
    .alu_desc     (alu_desc),
    .alu_op_done  (alu_op_done),
    .done_valid   (done_valid),
    .done_id      (done_id),
    .busy         (busy)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [DW-1:0] q0[$];
  bit            m_run;
  logic [DW-1:0] m_desc;
  bit            m_cur_id;
  bit            m_last_id;
  bit            m_done_v;
  bit            m_done_id;
  int            m_cnt;
  // Port-1 requester state
  bit            h1;
  logic [DW-1:0] d1;
  int            r1_mode;  // 0 off, 1 random, 2 always requesting
  // Observations for directed scenarios
  int            obs_valid_cycles, obs_done, obs_accepts, obs_run, obs_max_run;
  bit            obs_ids[$];
  int            tag_ctr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h expected=%h", nm, $time, act, exp);
    end
  endtask

  function automatic int op_len(input logic [DW-1:0] d);
    alu_op_desc_t t;
    t = d;
    if (t.rotate) return (t.rotate_count == 3'd0) ? 1 : int'(t.rotate_count);
    if (t.pair_op) return 8;
    return 4;
  endfunction

  function automatic logic [DW-1:0] rand_desc();
    logic [31:0] r;
    r = $urandom;
    return r[DW-1:0];
  endfunction

  // Non-rotate op with a unique tag so loss/duplication shows up in alu_desc
  function automatic logic [DW-1:0] mk_desc(input bit pair);
    alu_op_desc_t t;
    logic [31:0]  tg;
    t = '0;
    tag_ctr++;
    tg = tag_ctr;
    t.operation         = OP_ADD;
    t.pair_op           = pair;
    t.arg2_limit_length = tg[2:0];
    t.reg1              = tg[3];
    t.reg2              = tg[4];
    t.update_reg1       = tg[5];
    return t;
  endfunction

  task automatic clr_obs();
    obs_valid_cycles = 0;
    obs_done         = 0;
    obs_accepts      = 0;
    obs_run          = 0;
    obs_max_run      = 0;
    obs_ids.delete();
  endtask

  task automatic model_reset();
    q0.delete();
    m_run     = 0;
    m_desc    = '0;
    m_cur_id  = 0;
    m_last_id = 0;
    m_done_v  = 0;
    m_done_id = 0;
    m_cnt     = 0;
    h1        = 0;
  endtask

  task automatic drive_idle();
    req0_valid  = 0;
    req0_desc   = '0;
    req1_valid  = 0;
    req1_desc   = '0;
    flush       = 0;
    alu_op_done = 0;
  endtask

  // One clock cycle: drive inputs, compare outputs against the model, advance model
  task automatic step(input bit v0, input logic [DW-1:0] dsc0, input bit fl, input bit stall);
    bit done_in, c0, c1, win, issue, rdy, acc;
    @(negedge clk);
    if (!h1 && (r1_mode == 2 || (r1_mode == 1 && $urandom_range(0, 2) == 0))) begin
      h1 = 1;
      d1 = rand_desc();
    end
    done_in     = m_run && !stall && (m_cnt >= op_len(m_desc) - 1);
    req0_valid  = v0;
    req0_desc   = dsc0;
    flush       = fl;
    req1_valid  = h1;
    req1_desc   = d1;
    alu_op_done = done_in;
    rdy   = (q0.size() != DEPTH);
    c0    = (q0.size() != 0);
    c1    = DBG && h1;
    win   = (c0 && c1) ? !m_last_id : c1;
    issue = (!m_run || done_in) && (c0 || c1);
    #1;
    chk("alu_op_valid", 32'(alu_op_valid), 32'(m_run));
    chk("alu_desc", 32'(alu_desc), 32'(m_desc));
    chk("req0_ready", 32'(req0_ready), 32'(rdy));
    chk("req1_ready", 32'(req1_ready), 32'(issue && win));
    chk("done_valid", 32'(done_valid), 32'(m_done_v));
    chk("busy", 32'(busy), 32'(m_run || (q0.size() != 0)));
    if (m_done_v) chk("done_id", 32'(done_id), 32'(m_done_id));
    if (alu_op_valid) begin
      obs_valid_cycles++;
      obs_run++;
      if (obs_run > obs_max_run) obs_max_run = obs_run;
    end else begin
      obs_run = 0;
    end
    if (done_valid) begin
      obs_done++;
      obs_ids.push_back(done_id);
    end
    if (v0 && req0_ready && !fl) obs_accepts++;
    // Advance the model by one edge
    acc       = v0 && rdy && !fl;
    m_done_v  = m_run && done_in;
    m_done_id = DBG ? m_cur_id : 1'b0;
    if (issue) begin
      if (win) begin
        m_desc = d1;
        h1     = 0;
      end else begin
        m_desc = q0.pop_front();
      end
      m_cur_id  = win;
      m_last_id = win;
      m_run     = 1;
      m_cnt     = 0;
    end else if (m_run && done_in) begin
      m_run = 0;
    end else if (m_run && !stall) begin
      m_cnt++;
    end
    if (fl) q0.delete();
    if (acc) q0.push_back(dsc0);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    r1_mode = 0;
    if (!DBG) h1 = 0;
    for (int i = 0; i < 80 && (m_run || q0.size() != 0 || h1); i++) step(1'b0, '0, 1'b0, 1'b0);
    idle_steps(2);
    chk("drain_busy", 32'(busy), 32'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 0;
    drive_idle();
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1;
  endtask

  initial begin
    logic [DW-1:0] dp, ds;
    tag_ctr = 0;
    r1_mode = 0;
    d1      = '0;
    reset   = 0;
    drive_idle();
    model_reset();
    clr_obs();
    #6;
    chk("rst_alu_op_valid", 32'(alu_op_valid), 32'(0));
    chk("rst_alu_desc", 32'(alu_desc), 32'(0));
    chk("rst_req0_ready", 32'(req0_ready), 32'(1));
    chk("rst_req1_ready", 32'(req1_ready), 32'(0));
    chk("rst_done_valid", 32'(done_valid), 32'(0));
    chk("rst_done_id", 32'(done_id), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    @(negedge clk);
    @(negedge clk);
    reset = 1;

    // Single single-byte ADD
    clr_obs();
    step(1'b1, mk_desc(1'b0), 1'b0, 1'b0);
    idle_steps(10);
    chk("single_valid_cycles", 32'(obs_valid_cycles), 32'(4));
    chk("single_done_count", 32'(obs_done), 32'(1));
    chk("single_done_id", 32'(obs_ids.size() > 0 ? obs_ids[0] : 1'b1), 32'(0));

    // Back-to-back pair op then single op
    clr_obs();
    dp = mk_desc(1'b1);
    ds = mk_desc(1'b0);
    step(1'b1, dp, 1'b0, 1'b0);
    step(1'b1, ds, 1'b0, 1'b0);
    idle_steps(16);
    chk("b2b_continuous", 32'(obs_max_run), 32'(12));
    chk("b2b_valid_cycles", 32'(obs_valid_cycles), 32'(12));
    chk("b2b_done_count", 32'(obs_done), 32'(2));

    // Queue fills while the ALU is stalled: one in flight plus DEPTH queued
    clr_obs();
    for (int i = 0; i < 6; i++) step(1'b1, mk_desc(1'b0), 1'b0, 1'b1);
    chk("full_accepts", 32'(obs_accepts), 32'(3));
    chk("full_ready_low", 32'(req0_ready), 32'(0));
    idle_steps(20);
    chk("full_done_count", 32'(obs_done), 32'(3));

    // Flush while an 8-cycle op runs with two queued
    clr_obs();
    step(1'b1, mk_desc(1'b1), 1'b0, 1'b0);
    step(1'b1, mk_desc(1'b0), 1'b0, 1'b0);
    step(1'b1, mk_desc(1'b0), 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    idle_steps(12);
    chk("flush_done_count", 32'(obs_done), 32'(1));
    chk("flush_valid_end", 32'(alu_op_valid), 32'(0));
    chk("flush_busy_end", 32'(busy), 32'(0));

    // Both ports continuously requesting after reset
    do_reset();
    clr_obs();
    r1_mode = 2;
    for (int i = 0; i < 40; i++) step(1'b1, mk_desc(1'b0), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      chk("rr_order", 32'(obs_ids.size() > i ? obs_ids[i] : 1'bx), 32'(DBG ? (i % 2 == 0) : 0));
    drain();

    // Randomized traffic
    r1_mode = 1;
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, rand_desc(), $urandom_range(0, 31) == 0,
           $urandom_range(0, 7) == 0);
    drain();

    // Asynchronous reset in the middle of an op
    clr_obs();
    step(1'b1, mk_desc(1'b1), 1'b0, 1'b0);
    step(1'b1, mk_desc(1'b0), 1'b0, 1'b0);
    step(1'b1, mk_desc(1'b0), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    #2;
    reset = 0;
    drive_idle();
    #1;
    chk("arst_alu_op_valid", 32'(alu_op_valid), 32'(0));
    chk("arst_req0_ready", 32'(req0_ready), 32'(1));
    chk("arst_busy", 32'(busy), 32'(0));
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1;
    clr_obs();
    step(1'b1, mk_desc(1'b0), 1'b0, 1'b0);
    idle_steps(8);
    chk("arst_after_valid_cycles", 32'(obs_valid_cycles), 32'(4));
    chk("arst_after_done", 32'(obs_done), 32'(1));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
